// File: rtl/dense_weight_loader_pkg.sv
// Shared sizing constants for the runtime-loadable dense-layer weight store.
// Mirrors the values the dense layer takes from its shared constants header.
package dense_weight_loader_pkg;

    localparam int unsigned DATA_N   = 6;
    localparam int unsigned N_LEN    = 16;
    localparam int unsigned HID_DIM  = 120;
    localparam int unsigned CHAR_NUM = 40;

    localparam int unsigned DEF_DWIDTH = DATA_N * N_LEN;
    localparam int unsigned DEF_AWIDTH = 10;
    localparam int unsigned DEF_WORDS  = HID_DIM / DATA_N * CHAR_NUM;

    // Counter width that stays at least one bit wide for single-entry counts.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_weight_loader_ram.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
module dense_ram #(
    parameter int unsigned DWIDTH = 96,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned WORDS  = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] q
);

    (* ram_style = "block" *) logic [DWIDTH-1:0] mem [WORDS];

    logic [DWIDTH-1:0] q_q;

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= mem[raddr];
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dense_weight_loader.sv
// Streams NLEN-bit weights in, packs LANES of them MSB-first per word and writes
// consecutive RAM words; the read side behaves like the ROM it replaces.
module dense_weight_loader
    import dense_weight_loader_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH,
    parameter int unsigned WORDS  = DEF_WORDS,
    parameter int unsigned NLEN   = N_LEN,
    parameter int unsigned LANES  = DATA_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NLEN-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] q
);

    localparam int unsigned LW = cnt_width(LANES);
    localparam logic [DWIDTH-1:0] LANE_MASK = DWIDTH'({NLEN{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [AWIDTH-1:0] word_q, word_d;
    logic [DWIDTH-1:0] pack_q, pack_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] waddr_q, waddr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_c;
    logic              last_lane_c;
    logic              last_word_c;
    int unsigned       lane_shift_c;

    always_comb begin
        accept_c     = in_valid && in_ready_q;
        last_lane_c  = (lane_q == LW'(LANES - 1));
        last_word_c  = (word_q == AWIDTH'(WORDS - 1));
        // Lane 0 lands in the top slot so words read left-to-right like the weight files.
        lane_shift_c = ((LANES - 1) - 32'(lane_q)) * NLEN;

        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        pack_d  = pack_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    lane_d  = '0;
                    word_d  = '0;
                end
            end
            S_LOAD: begin
                if (accept_c) begin
                    pack_d = (pack_q & ~(LANE_MASK << lane_shift_c))
                           | (DWIDTH'(in_data) << lane_shift_c);
                    if (last_lane_c) begin
                        lane_d  = '0;
                        we_d    = 1'b1;
                        waddr_d = word_q;
                        wdata_d = pack_d;
                        if (last_word_c) begin
                            state_d = S_FLUSH;
                        end else begin
                            word_d = word_q + AWIDTH'(1);
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_FLUSH);
        done_d     = (state_d == S_DONE);
    end

    // A reset mid-load drops the partial word and any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            word_q     <= '0;
            pack_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            pack_q     <= pack_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

    dense_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .WORDS  (WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_q),
        .waddr (waddr_q),
        .wdata (wdata_q),
        .raddr (raddr),
        .q     (q)
    );

endmodule

// File: tb/tb_dense_weight_loader.sv
// Directed bench for dense_weight_loader: full, gapped and restarted loads plus read checks.
module tb_dense_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [9:0]  raddr;
    logic [95:0] q;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [95:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [4];

    always #5 clk = ~clk;

    dense_weight_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .raddr    (raddr),
        .q        (q)
    );

    always @(negedge clk) begin
        if (dut.we_q) we_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [95:0] exp_word(input logic [15:0] base, input int k);
        logic [95:0] w;
        w = '0;
        for (int j = 0; j < 6; j++) begin
            w[95-16*j -: 16] = base + 16'(6*k + j);
        end
        return w;
    endfunction

    task automatic rd(input string name, input int addr, input logic [95:0] exp);
        raddr = 10'(addr);
        tick();
        chk(name, q, exp);
    endtask

    // Full 4800-beat load; gap idle cycles before each beat, optional stray start and read-during-write probe.
    task automatic do_load(input logic [15:0] base, input int gap, input int stray_at,
                           input int rdw_k, input logic [15:0] old_base);
        int we0;
        we0   = we_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("in_ready_after_start", 96'(in_ready), 96'(1));
        chk("busy_after_start", 96'(busy), 96'(1));
        for (int i = 0; i < 4800; i++) begin
            if (i == stray_at) begin
                in_valid = 1'b0;
                start    = 1'b1;
                tick();
                start    = 1'b0;
            end
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_data  = base + 16'(i);
            in_valid = 1'b1;
            tick();
            if (rdw_k >= 0) begin
                if (i == 6*rdw_k + 5) raddr = 10'(rdw_k);
                if (i == 6*rdw_k + 6) chk("rdw_old", q, exp_word(old_base, rdw_k));
                if (i == 6*rdw_k + 7) chk("rdw_new", q, exp_word(base, rdw_k));
            end
        end
        in_valid = 1'b0;
        chk("done_low_in_flush", 96'(done), 96'(0));
        chk("busy_in_flush", 96'(busy), 96'(1));
        tick();
        chk("done_two_after_last", 96'(done), 96'(1));
        chk("busy_low_in_done", 96'(busy), 96'(0));
        chk("in_ready_low_in_done", 96'(in_ready), 96'(0));
        chk("we_pulse_count", 96'(we_cnt - we0), 96'(800));
    endtask

    initial begin
        vecs[0] = '{10'd0,   {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5}};
        vecs[1] = '{10'd799, {16'd4794, 16'd4795, 16'd4796, 16'd4797, 16'd4798, 16'd4799}};
        vecs[2] = '{10'd16,  {16'd96, 16'd97, 16'd98, 16'd99, 16'd100, 16'd101}};
        vecs[3] = '{10'd400, {16'd2400, 16'd2401, 16'd2402, 16'd2403, 16'd2404, 16'd2405}};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        raddr    = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", 96'(in_ready), 96'(0));
        chk("reset_busy", 96'(busy), 96'(0));
        chk("reset_done", 96'(done), 96'(0));
        chk("reset_q", q, 96'(0));

        // Back-to-back load of index data.
        do_load(16'h0000, 0, -1, -1, 16'h0000);
        for (int v = 0; v < 4; v++) rd("full_read", int'(vecs[v].addr), vecs[v].exp);

        // Gapped valid with a stray start mid-load; contents must match the first load.
        do_load(16'h0000, 2, 101, -1, 16'h0000);
        for (int v = 0; v < 4; v++) rd("gapped_read", int'(vecs[v].addr), vecs[v].exp);

        // Restart from DONE with offset data, probing read-during-write on word 3.
        do_load(16'h1000, 0, -1, 3, 16'h0000);
        rd("restart_addr0", 0, {16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005});
        rd("restart_addr799", 799, exp_word(16'h1000, 799));

        // Reset after 100 beats of a new load.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_data  = 16'hA000 + 16'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("midrst_in_ready", 96'(in_ready), 96'(0));
        chk("midrst_busy", 96'(busy), 96'(0));
        chk("midrst_done", 96'(done), 96'(0));
        chk("midrst_q", q, 96'(0));
        tick();
        rst = 1'b0;
        rd("midrst_word15", 15, exp_word(16'hA000, 15));
        rd("midrst_word16_untouched", 16, exp_word(16'h1000, 16));

        do_load(16'hA000, 0, -1, -1, 16'h0000);
        rd("reload_word0", 0, exp_word(16'hA000, 0));
        rd("reload_word15", 15, exp_word(16'hA000, 15));
        rd("reload_word16", 16, exp_word(16'hA000, 16));
        rd("reload_word799", 799, exp_word(16'hA000, 799));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
